// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared encodings and helpers for the MEM-stage load/store unit
// Purpose: access-size encodings, FSM state type and small decode helpers used by
//          load_store_unit and lsu_lane_align.
// Contents: WORD_LEN, SIZE_BYTE/SIZE_HALF/SIZE_WORD, lsu_state_e, is_sub_word(), is_misaligned().
package load_store_unit_pkg;

  localparam int WORD_LEN = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 is reserved and behaves as a word

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_e;

  function automatic logic is_sub_word(input logic [1:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_HALF);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr[0];
      default:   mis = (addr != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// rtl/load_store_unit_lane_align.sv - big-endian lane extract/extend and lane merge
// Purpose: combinational datapath for sub-word accesses on a 32-bit memory word.
//          Byte lane addr 0 is [31:24], addr 3 is [7:0]; half lane addr[1]=0 is [31:16].
// Ports:
//   word_i   in  32  word read from memory
//   addr_i   in   2  byte offset within the word
//   size_i   in   2  access size (byte/half/word)
//   signed_i in   1  sign-extend loaded lane when 1
//   wdata_i  in  16  right-justified store data (byte in [7:0], half in [15:0])
//   load_o   out 32  extracted and extended load value
//   merge_o  out 32  word with the addressed lane replaced by store data
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Big-endian: lane shift is (3 - offset) bytes, i.e. the inverted offset.
  assign byte_sh = {~addr_i, 3'b000};
  assign half_sh = {~addr_i[1], 4'b0000};
  assign byte_v  = 8'(word_i >> byte_sh);
  assign half_v  = 16'(word_i >> half_sh);

  always_comb begin
    load_o  = word_i;
    merge_o = word_i;
    case (size_i)
      SIZE_BYTE: begin
        load_o  = {{24{signed_i & byte_v[7]}}, byte_v};
        merge_o = (word_i & ~(32'h0000_00FF << byte_sh)) | ({24'h0, wdata_i[7:0]} << byte_sh);
      end
      SIZE_HALF: begin
        load_o  = {{16{signed_i & half_v[15]}}, half_v};
        merge_o = (word_i & ~(32'h0000_FFFF << half_sh)) | ({16'h0, wdata_i} << half_sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MIPS32 MEM-stage load/store unit for a word-only data memory
// Purpose: accepts byte/half/word loads and stores, issues aligned word reads/writes,
//          extends sub-word loads and performs read-modify-write for SB/SH.
// Option:  define MISALIGN_TRAP_EN to answer misaligned LH/SH/LW/SW with RESP_ERR and no
//          memory access; otherwise RESP_ERR is 0 and low address bits below the size are ignored.
// Ports:
//   CLK, RESET (async, active low)
//   REQ_VALID/REQ_READY handshake; REQ_WRITE, REQ_SIZE, REQ_SIGNED, REQ_ADDR, REQ_WDATA request
//   RESP_VALID (1-cycle pulse), RESP_RDATA (held load result), RESP_ERR (misalign trap)
//   MEM_READ_EN, MEM_WRITE_EN, MEM_ADDRESS (word aligned), MEM_WDATA, MEM_RDATA (registered memory)
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int WORD_LEN = load_store_unit_pkg::WORD_LEN
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic                REQ_WRITE,
  input  logic [1:0]          REQ_SIZE,
  input  logic                REQ_SIGNED,
  input  logic [WORD_LEN-1:0] REQ_ADDR,
  input  logic [WORD_LEN-1:0] REQ_WDATA,
  output logic                RESP_VALID,
  output logic [WORD_LEN-1:0] RESP_RDATA,
  output logic                RESP_ERR,
  output logic                MEM_READ_EN,
  output logic                MEM_WRITE_EN,
  output logic [WORD_LEN-1:0] MEM_ADDRESS,
  output logic [WORD_LEN-1:0] MEM_WDATA,
  input  logic [WORD_LEN-1:0] MEM_RDATA
);

  lsu_state_e          state_q, state_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [WORD_LEN-1:0] addr_q, addr_d;
  logic [WORD_LEN-1:0] wdata_q, wdata_d;
  logic [WORD_LEN-1:0] merge_q, merge_d;
  logic [WORD_LEN-1:0] rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                trap;
  logic [WORD_LEN-1:0] lane_load;
  logic [WORD_LEN-1:0] lane_merge;

`ifdef MISALIGN_TRAP_EN
  assign trap = is_misaligned(REQ_SIZE, REQ_ADDR[1:0]);
`else
  assign trap = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .word_i   (MEM_RDATA),
    .addr_i   (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .wdata_i  (wdata_q[15:0]),
    .load_o   (lane_load),
    .merge_o  (lane_merge)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          write_d  = REQ_WRITE;
          size_d   = REQ_SIZE;
          signed_d = REQ_SIGNED;
          addr_d   = REQ_ADDR;
          wdata_d  = REQ_WDATA;
          err_d    = trap;
          if (trap)
            state_d = ST_RESP;
          else if (REQ_WRITE && !is_sub_word(REQ_SIZE))
            state_d = ST_WRITE;
          else
            state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_MERGE;
      ST_MERGE: begin
        // MEM_RDATA is the registered read issued in ST_READ.
        if (write_q) begin
          merge_d = lane_merge;
          state_d = ST_WRITE;
        end else begin
          rdata_d = lane_load;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign REQ_READY    = (state_q == ST_IDLE);
  assign RESP_VALID   = (state_q == ST_RESP);
  assign RESP_RDATA   = rdata_q;
  assign RESP_ERR     = err_q & (state_q == ST_RESP);
  assign MEM_READ_EN  = (state_q == ST_READ);
  assign MEM_WRITE_EN = (state_q == ST_WRITE);
  assign MEM_ADDRESS  = {addr_q[WORD_LEN-1:2], 2'b00};
  // Full-word stores bypass the merge path.
  assign MEM_WDATA    = is_sub_word(size_q) ? merge_q : wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [1:0]  REQ_SIZE;
  logic        REQ_SIGNED;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RESP_VALID;
  logic [31:0] RESP_RDATA;
  logic        RESP_ERR;
  logic        MEM_READ_EN;
  logic        MEM_WRITE_EN;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;

  load_store_unit dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RESP_VALID(RESP_VALID), .RESP_RDATA(RESP_RDATA), .RESP_ERR(RESP_ERR),
    .MEM_READ_EN(MEM_READ_EN), .MEM_WRITE_EN(MEM_WRITE_EN), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Word memory seen by the DUT, and the reference byte image used by the model.
  logic [31:0] mem [0:15];
  logic [7:0]  rb  [0:63];
  logic [31:0] ref_last;

  int          rd_cnt = 0, wr_cnt = 0, resp_cnt = 0;
  logic [31:0] last_wr_addr, last_wr_data;

  always @(posedge CLK) begin
    if (MEM_READ_EN && MEM_WRITE_EN) begin
      n_fail++;
      $display("FAIL mem_overlap read_en=%b write_en=%b required not both 1", MEM_READ_EN, MEM_WRITE_EN);
    end
    if (MEM_READ_EN) begin
      MEM_RDATA <= mem[MEM_ADDRESS[5:2]];
      rd_cnt++;
    end
    if (MEM_WRITE_EN) begin
      mem[MEM_ADDRESS[5:2]] <= MEM_WDATA;
      wr_cnt++;
      last_wr_addr = MEM_ADDRESS;
      last_wr_data = MEM_WDATA;
    end
    if (RESP_VALID) resp_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Reference model: big-endian byte array, plain arithmetic.
  task automatic model_access(input logic w, input logic [1:0] sz, input logic sg,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] e_rdata, output logic e_err,
                              output int e_lat, output int e_rd, output int e_wr);
    int n, base;
    logic [31:0] v;
    logic mis;
    n    = nbytes(sz);
    mis  = (int'(addr) % n) != 0;
    base = int'(addr) - (int'(addr) % n);
`ifdef MISALIGN_TRAP_EN
    e_err = mis;
`else
    e_err = 1'b0;
`endif
    if (e_err) begin
      e_lat = 1; e_rd = 0; e_wr = 0;
    end else if (!w) begin
      v = 0;
      for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, rb[base + i]};
      if (sg && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 1);
      ref_last = v;
      e_lat = 3; e_rd = 1; e_wr = 0;
    end else begin
      for (int i = 0; i < n; i++) rb[base + i] = 8'(wdata >> (8*(n-1-i)));
      e_lat = (n == 4) ? 2 : 4; e_rd = (n == 4) ? 0 : 1; e_wr = 1;
    end
    e_rdata = ref_last;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int rds, output int wrs);
    int r0, w0;
    logic busy_bad;
    @(negedge CLK);
    chk("req_ready_idle", REQ_READY, 1);
    REQ_VALID = 1; REQ_WRITE = w; REQ_SIZE = sz; REQ_SIGNED = sg;
    REQ_ADDR = addr; REQ_WDATA = wdata;
    r0 = rd_cnt; w0 = wr_cnt; busy_bad = 0;
    @(negedge CLK);
    REQ_VALID = 0;
    lat = 1;
    if (REQ_READY) busy_bad = 1;
    while (!RESP_VALID && lat < 12) begin
      @(negedge CLK);
      lat++;
      if (REQ_READY) busy_bad = 1;
    end
    if (!RESP_VALID) lat = 99;
    chk("ready_low_busy", busy_bad, 0);
    rdata = RESP_RDATA; err = RESP_ERR;
    rds = rd_cnt - r0; wrs = wr_cnt - w0;
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wmem;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic sg,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] er, input logic [31:0] ew,
                              input int el, input logic ee);
    vec_t v;
    v.w = w; v.sz = sz; v.sg = sg; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = er; v.exp_wmem = ew; v.exp_lat = el; v.exp_err = ee;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    logic [31:0] g_rdata, e_rdata;
    logic        g_err, e_err;
    int          g_lat, e_lat, g_rd, e_rd, g_wr, e_wr;
    int          c, r0, w0, s0;

    tbl[0]  = mk(0, 2'b00, 1, 32'h11, 32'h0,        32'hFFFFFF99, 32'h0,        3, 0);
    tbl[1]  = mk(0, 2'b01, 0, 32'h12, 32'h0,        32'h0000AABB, 32'h0,        3, 0);
    tbl[2]  = mk(0, 2'b10, 0, 32'h10, 32'h0,        32'h8899AABB, 32'h0,        3, 0);
    tbl[3]  = mk(1, 2'b00, 0, 32'h12, 32'h00000055, 32'h8899AABB, 32'h889955BB, 4, 0);
    tbl[4]  = mk(0, 2'b10, 0, 32'h10, 32'h0,        32'h889955BB, 32'h0,        3, 0);
    tbl[5]  = mk(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 32'h889955BB, 32'hDEADBEEF, 2, 0);
    tbl[6]  = mk(0, 2'b10, 0, 32'h20, 32'h0,        32'hDEADBEEF, 32'h0,        3, 0);
    tbl[7]  = mk(0, 2'b01, 1, 32'h20, 32'h0,        32'hFFFFDEAD, 32'h0,        3, 0);
    tbl[8]  = mk(0, 2'b00, 0, 32'h23, 32'h0,        32'h000000EF, 32'h0,        3, 0);
    tbl[9]  = mk(0, 2'b00, 1, 32'h22, 32'h0,        32'hFFFFFFBE, 32'h0,        3, 0);
    tbl[10] = mk(1, 2'b01, 0, 32'h22, 32'h12348001, 32'hFFFFFFBE, 32'hDEAD8001, 4, 0);
    tbl[11] = mk(0, 2'b11, 1, 32'h20, 32'h0,        32'hDEAD8001, 32'h0,        3, 0);
`ifdef MISALIGN_TRAP_EN
    tbl[12] = mk(0, 2'b10, 0, 32'h22, 32'h0,        32'hDEAD8001, 32'h0,        1, 1);
    tbl[13] = mk(1, 2'b01, 0, 32'h21, 32'h00007777, 32'hDEAD8001, 32'h0,        1, 1);
    tbl[14] = mk(0, 2'b10, 0, 32'h20, 32'h0,        32'hDEAD8001, 32'h0,        3, 0);
`else
    tbl[12] = mk(0, 2'b10, 0, 32'h22, 32'h0,        32'hDEAD8001, 32'h0,        3, 0);
    tbl[13] = mk(1, 2'b01, 0, 32'h21, 32'h00007777, 32'hDEAD8001, 32'h77778001, 4, 0);
    tbl[14] = mk(0, 2'b10, 0, 32'h20, 32'h0,        32'h77778001, 32'h0,        3, 0);
`endif

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    for (int i = 0; i < 64; i++) rb[i] = 8'h0;
    mem[4] = 32'h8899AABB;
    rb[16] = 8'h88; rb[17] = 8'h99; rb[18] = 8'hAA; rb[19] = 8'hBB;
    ref_last = 32'h0;

    RESET = 0; REQ_VALID = 0; REQ_WRITE = 0; REQ_SIZE = 0; REQ_SIGNED = 0;
    REQ_ADDR = 0; REQ_WDATA = 0;
    repeat (2) @(negedge CLK);
    chk("rst_ready", REQ_READY, 1);
    chk("rst_resp_valid", RESP_VALID, 0);
    chk("rst_rdata", RESP_RDATA, 0);
    chk("rst_err", RESP_ERR, 0);
    chk("rst_mem_en", {MEM_READ_EN, MEM_WRITE_EN}, 0);
    RESET = 1;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      model_access(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wdata,
                   e_rdata, e_err, e_lat, e_rd, e_wr);
      do_req(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wdata,
             g_rdata, g_err, g_lat, g_rd, g_wr);
      chk($sformatf("tbl%0d_rdata", i), g_rdata, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_lat", i), g_lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_err", i), g_err, tbl[i].exp_err);
      chk($sformatf("tbl%0d_reads", i), g_rd, e_rd);
      chk($sformatf("tbl%0d_writes", i), g_wr, e_wr);
      if (tbl[i].w && !tbl[i].exp_err) begin
        chk($sformatf("tbl%0d_wr_addr", i), last_wr_addr, {tbl[i].addr[31:2], 2'b00});
        chk($sformatf("tbl%0d_wr_data", i), last_wr_data, tbl[i].exp_wmem);
      end
    end

    // REQ_VALID held high through RESP: not accepted there, accepted the cycle after.
    @(negedge CLK);
    r0 = wr_cnt; s0 = resp_cnt;
    REQ_VALID = 1; REQ_WRITE = 1; REQ_SIZE = 2'b10; REQ_SIGNED = 0;
    REQ_ADDR = 32'h24; REQ_WDATA = 32'hCAFEF00D;
    c = 0;
    do begin @(negedge CLK); c++; end while (!RESP_VALID && c < 10);
    chk("hold_first_lat", c, 2);
    chk("hold_ready_in_resp", REQ_READY, 0);
    @(negedge CLK);
    chk("hold_ready_after_resp", REQ_READY, 1);
    @(negedge CLK);
    REQ_VALID = 0;
    chk("hold_second_busy", REQ_READY, 0);
    c = 0;
    do begin @(negedge CLK); c++; end while (!RESP_VALID && c < 10);
    chk("hold_second_lat", c, 1);
    chk("hold_writes", wr_cnt - r0, 2);
    chk("hold_resps", resp_cnt - s0 + (RESP_VALID ? 0 : 0), 1);
    rb[36] = 8'hCA; rb[37] = 8'hFE; rb[38] = 8'hF0; rb[39] = 8'h0D;

    // Reset dropped during the WRITE cycle of an SH.
    @(negedge CLK);
    REQ_VALID = 1; REQ_WRITE = 1; REQ_SIZE = 2'b01; REQ_SIGNED = 0;
    REQ_ADDR = 32'h30; REQ_WDATA = 32'h0000ABCD;
    @(negedge CLK);
    REQ_VALID = 0;
    c = 0;
    while (!MEM_WRITE_EN && c < 10) begin @(negedge CLK); c++; end
    chk("rst_mid_write_seen", MEM_WRITE_EN, 1);
    w0 = wr_cnt; s0 = resp_cnt;
    #1 RESET = 0;
    #1;
    chk("rst_mid_write_drop", MEM_WRITE_EN, 0);
    chk("rst_mid_ready", REQ_READY, 1);
    repeat (2) @(negedge CLK);
    RESET = 1;
    repeat (2) @(negedge CLK);
    chk("rst_mid_no_resp", resp_cnt - s0, 0);
    chk("rst_mid_no_write", wr_cnt - w0, 0);
    chk("rst_mid_ready_after", REQ_READY, 1);
    chk("rst_mid_rdata_cleared", RESP_RDATA, 0);
    ref_last = 32'h0;

    // Randomized requests against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic        w, sg;
      logic [1:0]  sz;
      logic [31:0] a, d;
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 63));
      d  = $urandom;
      model_access(w, sz, sg, a, d, e_rdata, e_err, e_lat, e_rd, e_wr);
      do_req(w, sz, sg, a, d, g_rdata, g_err, g_lat, g_rd, g_wr);
      chk($sformatf("rnd%0d_rdata", i), g_rdata, e_rdata);
      chk($sformatf("rnd%0d_err", i), g_err, e_err);
      chk($sformatf("rnd%0d_lat", i), g_lat, e_lat);
      chk($sformatf("rnd%0d_reads", i), g_rd, e_rd);
      chk($sformatf("rnd%0d_writes", i), g_wr, e_wr);
    end

    // Final memory image must match the reference bytes.
    @(negedge CLK);
    for (int i = 0; i < 16; i++)
      chk($sformatf("mem_word%0d", i), mem[i],
          {rb[4*i], rb[4*i+1], rb[4*i+2], rb[4*i+3]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
